// File: rtl/fetch_exec_sequencer_pkg.sv
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Shared state encoding, strobe-vector fields and helpers for the
//            fetch/execute sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    typedef enum logic [2:0] {
        F1_ADDR = 3'd0,
        F1_REQ  = 3'd1,
        F1_WAIT = 3'd2,
        F2_ADDR = 3'd3,
        F2_REQ  = 3'd4,
        F2_WAIT = 3'd5,
        EXEC    = 3'd6,
        ERR     = 3'd7
    } state_t;

    localparam int c_STB_W         = 5;
    localparam int c_STB_MEM_START = 0;
    localparam int c_STB_MEM_RNW   = 1;
    localparam int c_STB_AR_LD     = 2;
    localparam int c_STB_PC_INC    = 3;
    localparam int c_STB_EXEC      = 4;

    // A zero length from the decoder means the full counter range.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned sc_w);
        return (len == 0) ? (32'd1 << sc_w) : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_exec_sequencer_step_decoder.sv
// ============================================================================
// Module   : step_decoder
// Brief    : Binary to one-hot decoder with enable; all outputs low when
//            disabled.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_decoder #(
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0]    i_sel,
    input  logic                i_en,
    output logic [2**SEL_W-1:0] o_onehot
);

    generate
        for (genvar gi = 0; gi < 2**SEL_W; gi++) begin : g_bit
            assign o_onehot[gi] = i_en && (i_sel == SEL_W'(gi));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/fetch_exec_sequencer.sv
// ============================================================================
// Module   : fetch_exec_sequencer
// Brief    : One/two word instruction fetch with ready handshake and timeout,
//            followed by a programmable-length, stallable execute counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_exec_sequencer
    import ctrl_pkg::*;
#(
    parameter int WORD_W  = 16,
    parameter int SC_W    = 4,
    parameter int EXT_BIT = 15,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_ready,
    input  logic [WORD_W-1:0]    mem_data,
    output logic                 mem_start,
    output logic                 mem_rnw,
    output logic                 ar_ld,
    output logic                 pc_inc,
    output logic [WORD_W-1:0]    ir1,
    output logic [WORD_W-1:0]    ir2,
    input  logic [SC_W-1:0]      exec_len,
    input  logic                 exec_stall,
    input  logic                 exec_done,
    output logic                 exec_valid,
    output logic [SC_W-1:0]      step,
    output logic [2**SC_W-1:0]   step_onehot,
    output logic                 bus_err
);

    localparam int                c_WC_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_WC_W-1:0] c_TO_LAST = c_WC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [c_WC_W-1:0] c_WC_ONE  = c_WC_W'(1);
    localparam logic [SC_W:0]     c_LEN_ONE = (SC_W + 1)'(1);
    localparam logic [SC_W-1:0]   c_ST_ONE  = SC_W'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WORD_W-1:0]    r_ir1;
    logic [WORD_W-1:0]    r_ir2;
    logic [SC_W-1:0]      r_step;
    logic [SC_W-1:0]      w_step_nxt;
    logic [c_WC_W-1:0]    r_wcnt;
    logic                 r_bus_err;
    logic                 w_ir1_ld;
    logic                 w_ir2_ld;
    logic                 w_timeout;
    logic                 w_last;
    logic                 w_in_wait;
    logic [SC_W:0]        w_eff_len;
    logic [c_STB_W-1:0]   w_stb;
    logic [c_STB_W-1:0]   w_stb_q;

    assign w_eff_len = (SC_W + 1)'(eff_len(32'(exec_len), SC_W));
    // >= rather than == so a decoder shrinking the length below the current step still ends EXEC.
    assign w_last    = ({1'b0, r_step} >= (w_eff_len - c_LEN_ONE));
    assign w_timeout = (TIMEOUT != 0) && (r_wcnt == c_TO_LAST);
    assign w_in_wait = (r_state == F1_WAIT) || (r_state == F2_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= F1_ADDR;
            r_ir1     <= '0;
            r_ir2     <= '0;
            r_step    <= '0;
            r_wcnt    <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            if (w_ir1_ld) r_ir1 <= mem_data;
            if (w_ir2_ld) r_ir2 <= mem_data;
            r_wcnt  <= (w_in_wait && (w_state_nxt == r_state)) ? r_wcnt + c_WC_ONE : '0;
            if (w_state_nxt == ERR) r_bus_err <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_ir1_ld    = 1'b0;
        w_ir2_ld    = 1'b0;
        w_stb       = '0;
        case (r_state)
            F1_ADDR, F2_ADDR: begin
                w_stb[c_STB_AR_LD]  = 1'b1;
                w_stb[c_STB_PC_INC] = 1'b1;
                w_state_nxt         = (r_state == F1_ADDR) ? F1_REQ : F2_REQ;
            end
            F1_REQ, F2_REQ: begin
                w_stb[c_STB_MEM_START] = 1'b1;
                w_stb[c_STB_MEM_RNW]   = 1'b1;
                w_state_nxt            = (r_state == F1_REQ) ? F1_WAIT : F2_WAIT;
            end
            F1_WAIT: begin
                if (mem_ready) begin
                    w_ir1_ld    = 1'b1;
                    w_state_nxt = mem_data[EXT_BIT] ? F2_ADDR : EXEC;
                end else if (w_timeout) begin
                    w_state_nxt = ERR;
                end
            end
            F2_WAIT: begin
                if (mem_ready) begin
                    w_ir2_ld    = 1'b1;
                    w_state_nxt = EXEC;
                end else if (w_timeout) begin
                    w_state_nxt = ERR;
                end
            end
            EXEC: begin
                w_stb[c_STB_EXEC] = 1'b1;
                if (exec_done || w_last) begin
                    w_state_nxt = F1_ADDR;
                    w_step_nxt  = '0;
                end else if (!exec_stall) begin
                    w_step_nxt = r_step + c_ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ERR;
            end
        endcase
    end

    assign w_stb_q     = rst ? '0 : w_stb;
    assign mem_start   = w_stb_q[c_STB_MEM_START];
    assign mem_rnw     = w_stb_q[c_STB_MEM_RNW];
    assign ar_ld       = w_stb_q[c_STB_AR_LD];
    assign pc_inc      = w_stb_q[c_STB_PC_INC];
    assign exec_valid  = w_stb_q[c_STB_EXEC];
    assign ir1         = r_ir1;
    assign ir2         = r_ir2;
    assign step        = r_step;
    assign bus_err     = r_bus_err;

    step_decoder #(
        .SEL_W (SC_W)
    ) u_step_decoder (
        .i_sel    (r_step),
        .i_en     (w_stb_q[c_STB_EXEC]),
        .o_onehot (step_onehot)
    );

endmodule

`default_nettype wire

// File: doc/fetch_exec_sequencer.md
Name: fetch_exec_sequencer

Overview:
Parametrised successor to the hardwired T-state control path: a sequencer that fetches one or two instruction words with a memory Ready handshake, then steps an execute counter of programmable length. Execute steps may stall on memory, and fetch waits are bounded by a timeout. It replaces the fixed 16-state sequence counter and its clear/inhibit terms. It sits between the memory interface and the instruction decoder. The decoder consumes ir1/ir2 and step_onehot, and returns exec_len, exec_stall and exec_done.

Parameters:
WORD_W, 16, instruction/memory word width
SC_W, 4, execute step counter width; max execute length 2**SC_W
EXT_BIT, 15, bit of ir1 that requests a second instruction word (must be < WORD_W)
TIMEOUT, 255, max cycles in a wait state before bus error; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mem_ready  in  1  memory completion; sampled only in WAIT states
mem_data  in  WORD_W  memory read data, valid with mem_ready
mem_start  out  1  one-cycle memory request pulse
mem_rnw  out  1  1 = read; always 1 during fetch
ar_ld  out  1  load address register from PC
pc_inc  out  1  increment PC
ir1  out  WORD_W  first instruction word (registered)
ir2  out  WORD_W  second instruction word (registered)
exec_len  in  SC_W  execute step count from decoder; 0 is treated as 2**SC_W
exec_stall  in  1  hold current execute step
exec_done  in  1  end execute after the current step
exec_valid  out  1  high in EXEC state
step  out  SC_W  current execute step, 0-based
step_onehot  out  2**SC_W  one-hot decode of step; all zero outside EXEC
bus_err  out  1  sticky timeout flag

Behaviour:
- Reset, synchronous, active-high:
  - state goes to F1_ADDR; ir1, ir2, step, wait counter and bus_err go to 0.
  - While rst is high, all strobes (mem_start, ar_ld, pc_inc, exec_valid) are forced to 0.
- All strobes are Moore outputs decoded from the state register. ir1, ir2, step and bus_err are registered.
- F1_ADDR (1 cycle): ar_ld=1, pc_inc=1. Next state F1_REQ.
- F1_REQ (1 cycle): mem_start=1, mem_rnw=1. Next state F1_WAIT. mem_ready is ignored in this state.
- F1_WAIT:
  - On mem_ready: ir1<=mem_data. Next state is F2_ADDR if mem_data[EXT_BIT]=1, otherwise EXEC with step=0.
  - Without mem_ready: the wait counter increments.
- F2_ADDR, F2_REQ, F2_WAIT mirror F1_ADDR, F1_REQ, F1_WAIT. On mem_ready: ir2<=mem_data, next state EXEC with step=0.
- ir2 holds its last value when a single-word instruction executes.
- Timeout:
  - The wait counter clears on entry to any WAIT state.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT with no mem_ready, go to ERR and set bus_err.
  - mem_ready in the same cycle the counter reaches TIMEOUT wins: normal transition, no error.
- EXEC:
  - exec_valid=1; step_onehot[step]=1.
  - Each cycle: if exec_done=1, or step = eff_len-1 (eff_len = exec_len, or 2**SC_W when exec_len=0), go to F1_ADDR and clear step to 0. exec_done overrides exec_stall.
  - Else if exec_stall=1, hold step.
  - Else step<=step+1.
  - step never wraps; the last step always terminates EXEC.
- exec_len is sampled every EXEC cycle. A decoder change mid-execute takes effect immediately.
- ERR: all strobes 0 and bus_err=1. Exits only on rst.
- Reset asserted mid-fetch or mid-execute aborts the current state with no completion strobes. The next fetch restarts at F1_ADDR.
- Execute-to-fetch latency: a 1-word instruction with exec_len=N and zero-wait memory occupies 3 fetch cycles + N execute cycles.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum (F1_ADDR, F1_REQ, F1_WAIT, F2_ADDR, F2_REQ, F2_WAIT, EXEC, ERR)
  - strobe-vector field constants
  - a function for the eff_len computation
- One natural sub-module: step_decoder (SC_W -> 2**SC_W one-hot with enable), reused by the ALU and bus-select decode.

Test Plan:
1. rst held 3 cycles, then released, ir1 word 0x0123, mem_ready 1 cycle after mem_start, exec_len=4 -> ar_ld and pc_inc in cycle 0, mem_start in cycle 1, ir1=0x0123, step_onehot walks 0x1, 0x2, 0x4, 0x8, then ar_ld again.
2. ir1=0x8005, then ir2=0x00AA, mem_ready delayed 3 cycles each time -> two mem_start pulses, ir2=0x00AA, EXEC entered only after the second ready.
3. EXEC with exec_len=6, exec_stall high at step 2 for 4 cycles -> step stays at 2 for 5 cycles total, then 3, 4, 5, and EXEC ends.
4. exec_done asserted at step 1 while exec_stall=1 and exec_len=0 -> next state F1_ADDR, step=0; separately, exec_len=0 with no exec_done -> exactly 16 execute cycles.
5. TIMEOUT=8, mem_ready never asserted -> bus_err rises 8 cycles after F1_WAIT entry, strobes stay 0 until rst; repeat with mem_ready on cycle 8 -> no error.
6. rst pulsed during F2_WAIT -> ir1=0, ir2=0, step=0, no ir2 load; sequencer restarts at F1_ADDR on the next cycle.
